// File: rtl/trackball_counter.sv
// Trackball position counter: counts toggles on the h/v movement clocks of a
// trackball emulator into two wrapping position counters readable by a CPU.
// Optional feature: define TRACKBALL_FLIP_EN to let the flip input invert the
// direction of both axes (screen-flip support).
//
// Read handshake: rd_stb is a single-cycle request (no backpressure). On the
// edge following rd_stb the counter chosen by rd_sel is captured into rd_data
// and rd_valid pulses high for exactly that one following cycle. rd_data then
// holds until the next read.
//
// Step pipeline: the raw movement clock is compared against its registered
// copy, and the resulting step strobe plus the direction sampled in that same
// cycle are registered. The counter applies the step one edge later, so a
// toggle in cycle n is visible in the counter in cycle n+2.
module trackball_counter #(
    parameter int CNT_W       = 8,
    parameter bit CLR_ON_READ = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flip,
    input  logic             h_clk,
    input  logic             h_dir,
    input  logic             v_clk,
    input  logic             v_dir,
    input  logic             rd_stb,
    input  logic             rd_sel,
    output logic [CNT_W-1:0] rd_data,
    output logic             rd_valid,
    output logic             h_moved,
    output logic             v_moved
);

    logic             h_clk_q, v_clk_q;
    logic             h_step, v_step;
    logic             h_down, v_down;
    logic             flip_eff;
    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic [CNT_W-1:0] h_next, v_next;
    logic             rd_h, rd_v;

`ifdef TRACKBALL_FLIP_EN
    assign flip_eff = flip;
`else
    // flip is kept as a port so both builds share one pinout
    logic flip_unused;
    assign flip_unused = flip;
    assign flip_eff    = 1'b0;
`endif

    assign rd_h = rd_stb & ~rd_sel;
    assign rd_v = rd_stb &  rd_sel;

    // Register movement clocks, detect toggles, and capture direction of each step
    always_ff @(posedge clk) begin
        if (reset) begin
            h_clk_q <= h_clk;
            v_clk_q <= v_clk;
            h_step  <= 1'b0;
            v_step  <= 1'b0;
            h_down  <= 1'b0;
            v_down  <= 1'b0;
        end else begin
            h_clk_q <= h_clk;
            v_clk_q <= v_clk;
            h_step  <= h_clk ^ h_clk_q;
            v_step  <= v_clk ^ v_clk_q;
            h_down  <= h_dir ^ flip_eff;
            v_down  <= v_dir ^ flip_eff;
        end
    end

    // Next counter values: optional clear-on-read first, then any pending step
    always_comb begin
        h_next = h_cnt;
        v_next = v_cnt;
        if (CLR_ON_READ && rd_h) h_next = '0;
        if (CLR_ON_READ && rd_v) v_next = '0;
        if (h_step) h_next = h_down ? h_next - CNT_W'(1) : h_next + CNT_W'(1);
        if (v_step) v_next = v_down ? v_next - CNT_W'(1) : v_next + CNT_W'(1);
    end

    // Counter, read capture and sticky moved-flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt    <= '0;
            v_cnt    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            h_moved  <= 1'b0;
            v_moved  <= 1'b0;
        end else begin
            h_cnt    <= h_next;
            v_cnt    <= v_next;
            rd_valid <= rd_stb;
            if (rd_stb) rd_data <= rd_sel ? v_cnt : h_cnt;
            // a step in the read cycle wins over the clear
            h_moved  <= h_step | (h_moved & ~rd_h);
            v_moved  <= v_step | (v_moved & ~rd_v);
        end
    end

endmodule

// File: doc/trackball_counter.md
TRACKBALL_COUNTER -- requirements
Module: trackball_counter

Interface
REQ-001 Parameter CNT_W, default 8, width of each axis position counter (4..16).
REQ-002 Parameter CLR_ON_READ, default 0; 1 = the selected axis counter clears when read.
REQ-003 Port clk  input  1  system clock; all logic on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port flip  input  1  screen-flip request; both axis directions invert when enabled (REQ-024).
REQ-006 Port h_clk  input  1  horizontal movement clock from the trackball emulator; each toggle is one step.
REQ-007 Port h_dir  input  1  horizontal direction: 0 = increment, 1 = decrement.
REQ-008 Port v_clk  input  1  vertical movement clock; each toggle is one step.
REQ-009 Port v_dir  input  1  vertical direction: 0 = increment, 1 = decrement.
REQ-010 Port rd_stb  input  1  single-cycle CPU read request.
REQ-011 Port rd_sel  input  1  read axis select: 0 = horizontal, 1 = vertical.
REQ-012 Port rd_data  output  CNT_W  registered counter value for the selected axis.
REQ-013 Port rd_valid  output  1  single-cycle pulse marking rd_data as updated.
REQ-014 Port h_moved, v_moved  output  1 each  sticky flag; set on any step, cleared by a read of that axis.

Function
REQ-015 h_clk, h_dir, v_clk and v_dir are each registered once (stage q); a step is detected when a clk input differs from its q copy, on both rising and falling toggles.
REQ-016 Step direction comes from the dir value sampled in the same cycle as the clk toggle, not from the q copy.
REQ-017 The counter updates on the clock edge following detection: an input toggle in cycle n is visible in the counter in cycle n+2.
REQ-018 Counter arithmetic is modulo 2^CNT_W: up from all-ones wraps to 0, down from 0 wraps to all-ones; no saturation.
REQ-019 The two axes are independent; simultaneous steps on both axes in one cycle are both counted.
REQ-020 A read (rd_stb=1) registers the counter selected by rd_sel into rd_data and pulses rd_valid for one cycle, on the edge following rd_stb. rd_data reflects counter state before any step counted on that same edge.
REQ-021 rd_data holds its value between reads.
REQ-022 With CLR_ON_READ=1, reading clears the selected counter. A step on that axis in the same cycle is not lost: the counter becomes +1 or all-ones (-1).
REQ-023 The moved flag of the read axis clears on a read. A step on that axis in the same cycle leaves the flag set.

Configuration
REQ-024 Macro TRACKBALL_FLIP_EN. When defined, flip=1 inverts the effective direction of both axes (dir 0 = decrement), sampled in the step cycle. When undefined, flip is ignored and the port is still present.

Reset
REQ-025 reset=1 forces both counters, rd_data, h_moved and v_moved to 0, rd_valid to 0, and the q stages to the current input values, so no spurious step is detected on release.
REQ-026 reset=1 overrides any step or read in the same cycle; no count is retained.
REQ-027 The first step after reset is counted if its toggle occurs in the first cycle after reset deasserts.

Verification
REQ-028 Reset, then 5 h_clk toggles with h_dir=0 and 3 with h_dir=1 -> read rd_sel=0 gives rd_data=2, rd_valid=1 for one cycle, h_moved=1 before the read and 0 after.
REQ-029 CNT_W=8, v counter at 0, one v_clk toggle with v_dir=1 -> read gives 8'hFF; then 2 toggles with v_dir=0 -> read gives 8'h01.
REQ-030 CLR_ON_READ=1, h counter=7, rd_stb with rd_sel=0 in the same cycle as an h_clk toggle with h_dir=0 -> rd_data=7, next read gives 1.
REQ-031 Both axes toggle in the same cycle, 10 times each (h up, v down) -> h=10, v=8'hF6.
REQ-032 TRACKBALL_FLIP_EN defined, flip=1, 4 h_clk toggles with h_dir=0 -> h=8'hFC; with the macro undefined, the same stimulus gives h=4.
REQ-033 reset asserted mid-stream with h=9 and a toggle in the reset cycle -> h=0, no step after release, rd_data=0.
